// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared types and constants for the ALU input front-end.
//   - state_t      : controller states (IDLE, DEBOUNCE, LATCH, WAIT_RELEASE)
//   - BTN_NONE     : button code meaning "no operation selected"
//   - MODE_*       : ALU mode switch encodings
//   - is_one_cold  : true when exactly one active-low button is pressed
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    LATCH        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] BTN_NONE   = 4'b1111;
  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_LOGIC = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;

  // A press counts only when a single button is down; chords and the
  // all-released pattern are both rejected.
  function automatic logic is_one_cold(input logic [3:0] btn);
    return (btn == 4'b1110) || (btn == 4'b1101) ||
           (btn == 4'b1011) || (btn == 4'b0111);
  endfunction

endpackage

// File: rtl/alu_input_ctrl_sync_2ff.sv
// sync_2ff
//   Generic two-flop synchronizer for asynchronous inputs.
//   Parameters: W (width), RESET_VAL (value both flops take in reset).
//   Ports:
//     clk - system clock
//     rst - asynchronous active-high reset
//     d   - raw asynchronous input
//     q   - synchronized output (two clocks of latency)
module sync_2ff #(
  parameter int             W         = 1,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; the second gives it a full cycle to
  // settle before anything downstream looks at the value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alu_input_ctrl.sv
// alu_input_ctrl
//   Registered front-end for the 4-bit ALU. Synchronizes and debounces the
//   four active-low operation buttons, and on an accepted single press
//   snapshots the mode and operand switches. Outputs then stay frozen until
//   the next accepted press.
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     buttons_n[3:0]      - raw active-low operation buttons
//     mode_sw[1:0]        - raw mode switches
//     a_sw, b_sw [N-1:0]  - raw operand switches
//     A_num, B_num        - latched operands to the ALU
//     operations_buttons  - latched one-cold op code (1111 = none)
//     change_mode         - latched mode to the ALU
//     op_valid            - one-cycle pulse when new values appear
//     busy                - high whenever the controller is not idle
module alu_input_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   buttons_n,
  input  logic [1:0]   mode_sw,
  input  logic [N-1:0] a_sw,
  input  logic [N-1:0] b_sw,
  output logic [N-1:0] A_num,
  output logic [N-1:0] B_num,
  output logic [3:0]   operations_buttons,
  output logic [1:0]   change_mode,
  output logic         op_valid,
  output logic         busy
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       btn_s;
  logic [1:0]       mode_s;
  logic [N-1:0]     a_s;
  logic [N-1:0]     b_s;

  state_t           state;
  state_t           next_state;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;

  logic             load_cand;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             do_latch;

  sync_2ff #(.W(4), .RESET_VAL(BTN_NONE)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (buttons_n),
    .q   (btn_s)
  );

  sync_2ff #(.W(2), .RESET_VAL(MODE_ARITH)) u_sync_mode (
    .clk (clk),
    .rst (rst),
    .d   (mode_sw),
    .q   (mode_s)
  );

  sync_2ff #(.W(N), .RESET_VAL('0)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (a_sw),
    .q   (a_s)
  );

  sync_2ff #(.W(N), .RESET_VAL('0)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (b_sw),
    .q   (b_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath control. The same counter times both the press
  // and the release; during release any non-idle pattern (bounce or a second
  // button) restarts the count instead of aborting.
  always_comb begin
    next_state = state;
    load_cand  = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    do_latch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_one_cold(btn_s)) begin
          load_cand  = 1'b1;
          cnt_clear  = 1'b1;
          next_state = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (btn_s != cand) begin
          next_state = IDLE;
        end else if (cnt == CNT_LAST) begin
          next_state = LATCH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      LATCH: begin
        do_latch   = 1'b1;
        cnt_clear  = 1'b1;
        next_state = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (btn_s != BTN_NONE) begin
          cnt_clear = 1'b1;
        end else if (cnt == CNT_LAST) begin
          next_state = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Candidate button code and the shared debounce counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= BTN_NONE;
      cnt  <= '0;
    end else begin
      if (load_cand) begin
        cand <= btn_s;
      end
      if (cnt_clear) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Output registers. The snapshot and op_valid are loaded on the same edge
  // so the pulse lines up with the first cycle of the new values. busy is
  // registered from next_state so it is a clean flop output equal to
  // (state != IDLE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A_num              <= '0;
      B_num              <= '0;
      operations_buttons <= BTN_NONE;
      change_mode        <= MODE_ARITH;
      op_valid           <= 1'b0;
      busy               <= 1'b0;
    end else begin
      op_valid <= do_latch;
      busy     <= (next_state != IDLE);
      if (do_latch) begin
        operations_buttons <= cand;
        change_mode        <= mode_s;
        A_num              <= a_s;
        B_num              <= b_s;
      end
    end
  end

endmodule
